// File: rtl/audio_soft_mute.sv
// Stereo soft-mute stage: applies a per-frame linear gain ramp to a left/right
// sample stream behind a single-register valid/ready output stage.
module audio_soft_mute #(
    parameter int audio_width = 16,
    parameter int ramp_shift  = 8
) (
    input  logic                          clk,
    input  logic                          nreset,
    input  logic                          i_mute,
    input  logic                          i_valid,
    output logic                          i_ready,
    input  logic                          i_is_left,
    input  logic signed [audio_width-1:0] i_audio,
    output logic                          o_valid,
    input  logic                          o_ready,
    output logic                          o_is_left,
    output logic signed [audio_width-1:0] o_audio,
    output logic                          o_muted
);

    localparam int gain_width = ramp_shift + 1;
    localparam int prod_width = audio_width + ramp_shift + 1;

    localparam logic [1:0] st_muted     = 2'd0;
    localparam logic [1:0] st_ramp_up   = 2'd1;
    localparam logic [1:0] st_unity     = 2'd2;
    localparam logic [1:0] st_ramp_down = 2'd3;

    localparam logic [gain_width-1:0] gain_zero = {gain_width{1'b0}};
    localparam logic [gain_width-1:0] gain_one  = {{ramp_shift{1'b0}}, 1'b1};
    localparam logic [gain_width-1:0] gain_full = {1'b1, {ramp_shift{1'b0}}};
    localparam logic [gain_width-1:0] gain_top  = gain_full - gain_one;

    logic [1:0]                    state_r;
    logic [1:0]                    state_next_s;
    logic [gain_width-1:0]         gain_r;
    logic [gain_width-1:0]         gain_next_s;
    logic                          muted_r;
    logic                          valid_r;
    logic                          is_left_r;
    logic signed [audio_width-1:0] audio_r;
    logic                          accept_s;
    logic                          boundary_s;
    logic signed [prod_width-1:0]  audio_ext_s;
    logic signed [prod_width-1:0]  gain_ext_s;
    logic signed [prod_width-1:0]  product_s;
    logic signed [prod_width-1:0]  shifted_s;

    assign i_ready    = ~valid_r | o_ready;
    assign accept_s   = i_valid & i_ready;
    assign boundary_s = accept_s & ~i_is_left;

    // Full-width signed product; the arithmetic shift floors toward minus infinity.
    always_comb begin
        audio_ext_s = {{(prod_width-audio_width){i_audio[audio_width-1]}}, i_audio};
        gain_ext_s  = {{(prod_width-gain_width){1'b0}}, gain_r};
        product_s   = audio_ext_s * gain_ext_s;
        shifted_s   = product_s >>> ramp_shift;
    end

    // Ramp state machine, advanced only when a right sample is accepted.
    always_comb begin
        state_next_s = state_r;
        gain_next_s  = gain_r;
        if (boundary_s) begin
            case (state_r)
                st_muted: begin
                    if (!i_mute) begin
                        state_next_s = st_ramp_up;
                        gain_next_s  = gain_one;
                    end else begin
                        state_next_s = st_muted;
                        gain_next_s  = gain_zero;
                    end
                end
                st_ramp_up: begin
                    if (i_mute) begin
                        gain_next_s  = gain_r - gain_one;
                        state_next_s = (gain_r == gain_one) ? st_muted : st_ramp_down;
                    end else begin
                        gain_next_s  = gain_r + gain_one;
                        state_next_s = (gain_r == gain_top) ? st_unity : st_ramp_up;
                    end
                end
                st_unity: begin
                    if (i_mute) begin
                        state_next_s = st_ramp_down;
                        gain_next_s  = gain_top;
                    end else begin
                        state_next_s = st_unity;
                        gain_next_s  = gain_full;
                    end
                end
                st_ramp_down: begin
                    // Gain reaching either end lands in the matching terminal state.
                    if (!i_mute) begin
                        gain_next_s  = gain_r + gain_one;
                        state_next_s = (gain_r == gain_top) ? st_unity : st_ramp_up;
                    end else begin
                        gain_next_s  = gain_r - gain_one;
                        state_next_s = (gain_r == gain_one) ? st_muted : st_ramp_down;
                    end
                end
                default: begin
                    state_next_s = st_muted;
                    gain_next_s  = gain_zero;
                end
            endcase
        end else begin
            state_next_s = state_r;
            gain_next_s  = gain_r;
        end
    end

    // State, gain and mute flag registers.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_r <= st_muted;
            gain_r  <= gain_zero;
            muted_r <= 1'b1;
        end else begin
            state_r <= state_next_s;
            gain_r  <= gain_next_s;
            muted_r <= (state_next_s == st_muted);
        end
    end

    // Output register: loads on accept, holds under backpressure, drains when taken.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            valid_r   <= 1'b0;
            is_left_r <= 1'b0;
            audio_r   <= {audio_width{1'b0}};
        end else if (accept_s) begin
            valid_r   <= 1'b1;
            is_left_r <= i_is_left;
            audio_r   <= shifted_s[audio_width-1:0];
        end else if (o_ready) begin
            valid_r   <= 1'b0;
        end
    end

    assign o_valid   = valid_r;
    assign o_is_left = is_left_r;
    assign o_audio   = audio_r;
    assign o_muted   = muted_r;

endmodule
